// File: rtl/track_para_pkg.sv
`default_nettype none
// ============================================================================
// Module  : track_para_pkg
// Brief   : Shared types and constants for the track-parameter table source.
// Revision: 1.0 - initial release
// ============================================================================
package track_para_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } track_state_e;

    localparam int C_WORD_NUM   = 128;
    localparam int C_BURST_LEN  = 16;
    localparam int C_GAP_CYCLES = 4;
    localparam int C_DATA_W     = 32;

    // Word positions of the individual fields inside one parameter table
    localparam int C_FLD_DDR_ADDR    = 0;
    localparam int C_FLD_DS_FIRST    = 1;
    localparam int C_FLD_DS_LAST     = 2;
    localparam int C_FLD_LIGHT_SPOT  = 3;
    localparam int C_FLD_TRACK_ALIGN = 4;
    localparam int C_FLD_LOWPASS     = 5;
    localparam int C_FLD_FIR_FIRST   = 6;
    localparam int C_FLD_FIR_LAST    = 56;

    function automatic logic is_fir_tap(input int idx);
        return (idx >= C_FLD_FIR_FIRST) && (idx <= C_FLD_FIR_LAST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/track_para_if.sv
`default_nettype none
// ============================================================================
// Module  : track_para_if
// Brief   : Host config bus plus consumer read stream of the parameter source.
// Revision: 1.0 - initial release
// ============================================================================
interface track_para_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) ();

    logic              cfg_wr_en_i;
    logic [ADDR_W-1:0] cfg_wr_addr_i;
    logic [DATA_W-1:0] cfg_wr_data_i;
    logic              cfg_commit_i;
    logic              cfg_pending_o;
    logic              cfg_wr_drop_o;
    logic              track_para_ren_i;
    logic              track_para_burst_end_o;
    logic              track_para_vld_o;
    logic [DATA_W-1:0] track_para_data_o;

    // Host and consumer side
    modport master (
        output cfg_wr_en_i,
        output cfg_wr_addr_i,
        output cfg_wr_data_i,
        output cfg_commit_i,
        input  cfg_pending_o,
        input  cfg_wr_drop_o,
        output track_para_ren_i,
        input  track_para_burst_end_o,
        input  track_para_vld_o,
        input  track_para_data_o
    );

    // Table source side
    modport slave (
        input  cfg_wr_en_i,
        input  cfg_wr_addr_i,
        input  cfg_wr_data_i,
        input  cfg_commit_i,
        output cfg_pending_o,
        output cfg_wr_drop_o,
        input  track_para_ren_i,
        output track_para_burst_end_o,
        output track_para_vld_o,
        output track_para_data_o
    );

endinterface
`default_nettype wire

// File: rtl/track_para_source_dpram.sv
`default_nettype none
// ============================================================================
// Module  : track_para_source_dpram
// Brief   : Simple dual-port 2*WORD_NUM x DATA_W table RAM, registered read.
// Revision: 1.0 - initial release
// ============================================================================
module track_para_source_dpram #(
    parameter int WORD_NUM = 128,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W:0]   wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W:0]   rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int DEPTH = 2 * WORD_NUM;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Port addresses always differ in the bank bit while a read is live
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/track_para_source.sv
`default_nettype none
// ============================================================================
// Module  : track_para_source
// Brief   : Double-buffered parameter table streamed as gapped 16-beat bursts.
//           Optional macro TRACK_PARA_CSUM_EN: final beat carries XOR checksum.
// Revision: 1.0 - initial release
// ============================================================================
module track_para_source
    import track_para_pkg::*;
#(
    parameter int WORD_NUM   = C_WORD_NUM,
    parameter int BURST_LEN  = C_BURST_LEN,
    parameter int GAP_CYCLES = C_GAP_CYCLES,
    parameter int ADDR_W     = $clog2(WORD_NUM)
) (
    input  wire logic   clk_i,
    input  wire logic   rst_n_i,
    track_para_if.slave bus
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [GAP_W-1:0]  C_LAST_GAP  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] C_LAST_IDX  = ADDR_W'(WORD_NUM - 1);

    track_state_e          state_q, state_d;
    logic [ADDR_W-1:0]     idx_q, idx_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  ren_dly_q, ren_dly_d;
    logic                  active_q, active_d;
    logic                  pending_q, pending_d;
    logic                  drop_q, drop_d;
    logic                  burst_end_q, burst_end_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  vld_q, vld_d;
    logic [C_DATA_W-1:0]   data_q, data_d;

    logic                  ren;
    logic                  ren_rise;
    logic                  rd_en;
    logic                  start;
    logic                  swap;
    logic                  ram_wr_en;
    logic [C_DATA_W-1:0]   rd_data;

`ifdef TRACK_PARA_CSUM_EN
    logic                  rd_last_q, rd_last_d;
    logic [C_DATA_W-1:0]   csum_q, csum_d;
`endif

    assign ren      = bus.track_para_ren_i;
    assign ren_rise = ren & ~ren_dly_q;

    // ------------------------------------------------------------------
    // Stream sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        rd_en   = 1'b0;
        start   = 1'b0;
        swap    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A starting stream wins over a pending swap in the same cycle
                if (ren_rise) begin
                    start   = 1'b1;
                    state_d = ST_BURST;
                    idx_d   = '0;
                    beat_d  = '0;
                end else if (pending_q) begin
                    swap = 1'b1;
                end
            end

            ST_BURST: begin
                if (!ren) begin
                    state_d = ST_IDLE;
                end else begin
                    rd_en  = 1'b1;
                    idx_d  = idx_q + 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == C_LAST_BEAT) begin
                        if (idx_q == C_LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (!ren) begin
                    state_d = ST_IDLE;
                end else if (gap_q == C_LAST_GAP) begin
                    state_d = ST_BURST;
                    beat_d  = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            ST_DONE: begin
                if (!ren) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Host configuration: shadow writes, commit and bank swap
    // ------------------------------------------------------------------
    always_comb begin
        ren_dly_d   = ren;
        ram_wr_en   = bus.cfg_wr_en_i & ~pending_q;
        drop_d      = drop_q | (bus.cfg_wr_en_i & pending_q);
        pending_d   = swap ? 1'b0 : (pending_q | bus.cfg_commit_i);
        active_d    = swap ? ~active_q : active_q;
        burst_end_d = swap;
    end

    // ------------------------------------------------------------------
    // Read pipeline: RAM stage then output register
    // ------------------------------------------------------------------
    always_comb begin
        rd_vld_d = rd_en;
        vld_d    = rd_vld_q;
        data_d   = data_q;
`ifdef TRACK_PARA_CSUM_EN
        rd_last_d = rd_en & (idx_q == C_LAST_IDX);
        csum_d    = csum_q;
        // Clearing wins so a beat still in flight from an aborted stream is excluded
        if (start) begin
            csum_d = '0;
        end else if (rd_vld_q && !rd_last_q) begin
            csum_d = csum_q ^ rd_data;
        end
        if (rd_vld_q) begin
            data_d = rd_last_q ? csum_q : rd_data;
        end
`else
        if (rd_vld_q) begin
            data_d = rd_data;
        end
`endif
    end

    track_para_source_dpram #(
        .WORD_NUM (WORD_NUM),
        .ADDR_W   (ADDR_W),
        .DATA_W   (C_DATA_W)
    ) u_dpram (
        .clk_i     (clk_i),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i ({~active_q, bus.cfg_wr_addr_i}),
        .wr_data_i (bus.cfg_wr_data_i),
        .rd_en_i   (rd_en),
        .rd_addr_i ({active_q, idx_q}),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            beat_q      <= '0;
            gap_q       <= '0;
            // Held high so a read-enable already asserted across reset is not an edge
            ren_dly_q   <= 1'b1;
            active_q    <= 1'b0;
            pending_q   <= 1'b0;
            drop_q      <= 1'b0;
            burst_end_q <= 1'b0;
            rd_vld_q    <= 1'b0;
            vld_q       <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            beat_q      <= beat_d;
            gap_q       <= gap_d;
            ren_dly_q   <= ren_dly_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            drop_q      <= drop_d;
            burst_end_q <= burst_end_d;
            rd_vld_q    <= rd_vld_d;
            vld_q       <= vld_d;
            data_q      <= data_d;
        end
    end

`ifdef TRACK_PARA_CSUM_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_last_q <= 1'b0;
            csum_q    <= '0;
        end else begin
            rd_last_q <= rd_last_d;
            csum_q    <= csum_d;
        end
    end
`endif

    assign bus.cfg_pending_o          = pending_q;
    assign bus.cfg_wr_drop_o          = drop_q;
    assign bus.track_para_burst_end_o = burst_end_q;
    assign bus.track_para_vld_o       = vld_q;
    assign bus.track_para_data_o      = data_q;

endmodule
`default_nettype wire

// File: tb/tb_track_para_source.sv
`default_nettype none
// ============================================================================
// Module  : tb_track_para_source
// Brief   : Directed bench for track_para_source (vector table + stream sequences).
// Revision: 1.0 - initial release
// ============================================================================
module tb_track_para_source;
    import track_para_pkg::*;

    localparam int WN  = C_WORD_NUM;
    localparam int BL  = C_BURST_LEN;
    localparam int GAP = C_GAP_CYCLES;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    track_para_if #(.ADDR_W(7), .DATA_W(32)) bus_if ();

    track_para_source #(
        .WORD_NUM   (WN),
        .BURST_LEN  (BL),
        .GAP_CYCLES (GAP),
        .ADDR_W     (7)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_if)
    );

    typedef struct packed {
        logic        wr_en;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic        commit;
        logic        e_pend;
        logic        e_drop;
        logic        e_be;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          be_cnt  = 0;
    int          t_ren;
    int          base;
    int          be_base;
    logic [31:0] log_data [$];
    int          log_cyc  [$];
    logic [31:0] exp_tbl  [WN];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_if.track_para_vld_o) begin
            log_data.push_back(bus_if.track_para_data_o);
            log_cyc.push_back(cyc);
        end
        if (bus_if.track_para_burst_end_o) be_cnt <= be_cnt + 1;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] pat(input int sel, input int i);
        case (sel)
            0:       return 32'hA500_0000 + 32'(i);
            1:       return 32'h5A00_0000 + 32'(i);
            default: return 32'(i) * 32'h9E37_79B9;
        endcase
    endfunction

    task automatic load_exp(input int sel);
        logic [31:0] x;
        for (int i = 0; i < WN; i++) exp_tbl[i] = pat(sel, i);
        x = '0;
        for (int i = 0; i < WN - 1; i++) x = x ^ exp_tbl[i];
`ifdef TRACK_PARA_CSUM_EN
        exp_tbl[WN-1] = x;
`endif
    endtask

    task automatic write_table(input int sel);
        for (int i = 0; i < WN; i++) begin
            bus_if.cfg_wr_en_i   = 1'b1;
            bus_if.cfg_wr_addr_i = 7'(i);
            bus_if.cfg_wr_data_i = pat(sel, i);
            step(1);
        end
        bus_if.cfg_wr_en_i = 1'b0;
    endtask

    task automatic commit_pulse();
        bus_if.cfg_commit_i = 1'b1;
        step(1);
        bus_if.cfg_commit_i = 1'b0;
    endtask

    task automatic start_stream();
        bus_if.track_para_ren_i = 1'b1;
        t_ren   = cyc;
        base    = log_data.size();
        be_base = be_cnt;
    endtask

    task automatic check_stream(input string name, input int n_exp);
        int n;
        int derr;
        int terr;
        n    = log_data.size() - base;
        derr = 0;
        terr = 0;
        check({name, "_count"}, n, n_exp);
        for (int k = 0; k < n && k < n_exp; k++) begin
            if (log_data[base+k] !== exp_tbl[k]) derr++;
            if (log_cyc[base+k] != t_ren + 3 + k + (k / BL) * GAP) terr++;
        end
        check({name, "_data_errs"}, derr, 0);
        check({name, "_timing_errs"}, terr, 0);
    endtask

    initial begin
        vec_t vecs [9];
        int   n;
        logic reached;

        vecs[0] = '{wr_en:1'b0, addr:7'd0, wdata:32'h0,         commit:1'b1, e_pend:1'b1, e_drop:1'b0, e_be:1'b0};
        vecs[1] = '{wr_en:1'b0, addr:7'd0, wdata:32'h0,         commit:1'b0, e_pend:1'b0, e_drop:1'b0, e_be:1'b1};
        vecs[2] = '{wr_en:1'b0, addr:7'd0, wdata:32'h0,         commit:1'b0, e_pend:1'b0, e_drop:1'b0, e_be:1'b0};
        vecs[3] = '{wr_en:1'b1, addr:7'd3, wdata:32'h1234_5678, commit:1'b0, e_pend:1'b0, e_drop:1'b0, e_be:1'b0};
        vecs[4] = '{wr_en:1'b0, addr:7'd0, wdata:32'h0,         commit:1'b1, e_pend:1'b1, e_drop:1'b0, e_be:1'b0};
        vecs[5] = '{wr_en:1'b0, addr:7'd0, wdata:32'h0,         commit:1'b1, e_pend:1'b0, e_drop:1'b0, e_be:1'b1};
        vecs[6] = '{wr_en:1'b0, addr:7'd0, wdata:32'h0,         commit:1'b1, e_pend:1'b1, e_drop:1'b0, e_be:1'b0};
        vecs[7] = '{wr_en:1'b0, addr:7'd0, wdata:32'h0,         commit:1'b0, e_pend:1'b0, e_drop:1'b0, e_be:1'b1};
        vecs[8] = '{wr_en:1'b0, addr:7'd0, wdata:32'h0,         commit:1'b0, e_pend:1'b0, e_drop:1'b0, e_be:1'b0};

        bus_if.cfg_wr_en_i      = 1'b0;
        bus_if.cfg_wr_addr_i    = '0;
        bus_if.cfg_wr_data_i    = '0;
        bus_if.cfg_commit_i     = 1'b0;
        bus_if.track_para_ren_i = 1'b0;

        // Reset state
        step(3);
        check("rst_pending", bus_if.cfg_pending_o, 0);
        check("rst_drop", bus_if.cfg_wr_drop_o, 0);
        check("rst_burst_end", bus_if.track_para_burst_end_o, 0);
        check("rst_vld", bus_if.track_para_vld_o, 0);
        check("rst_data", bus_if.track_para_data_o, 0);
        rst_n = 1'b1;
        step(2);

        // Shadow bank 1 gets the A5 table, then the commit/swap vector table
        write_table(0);
        for (int i = 0; i < 9; i++) begin
            bus_if.cfg_wr_en_i   = vecs[i].wr_en;
            bus_if.cfg_wr_addr_i = vecs[i].addr;
            bus_if.cfg_wr_data_i = vecs[i].wdata;
            bus_if.cfg_commit_i  = vecs[i].commit;
            step(1);
            check($sformatf("v%0d_pending", i), bus_if.cfg_pending_o, vecs[i].e_pend);
            check($sformatf("v%0d_drop", i), bus_if.cfg_wr_drop_o, vecs[i].e_drop);
            check($sformatf("v%0d_burst_end", i), bus_if.track_para_burst_end_o, vecs[i].e_be);
            check($sformatf("v%0d_vld", i), bus_if.track_para_vld_o, 0);
        end
        bus_if.cfg_wr_en_i  = 1'b0;
        bus_if.cfg_commit_i = 1'b0;
        step(2);

        // Full uninterrupted stream, ren held through DONE
        load_exp(0);
        start_stream();
        step(200);
        check_stream("full", WN);
        check("full_no_burst_end", be_cnt - be_base, 0);
        bus_if.track_para_ren_i = 1'b0;
        step(2);

        // Consumer drops ren after 126 beats; only the in-flight beat follows
        start_stream();
        n = 0;
        reached = 1'b0;
        for (int c = 0; c < 400; c++) begin
            step(1);
            if (bus_if.track_para_vld_o) n++;
            if (n == 126) begin
                reached = 1'b1;
                break;
            end
        end
        check("abort_reached", reached, 1);
        bus_if.track_para_ren_i = 1'b0;
        step(10);
        check("abort_count", log_data.size() - base, 127);
        check("abort_last", log_data[log_data.size()-1], 32'hA500_007E);

        // Restart from word 0, then abort inside the first gap
        start_stream();
        step(19);
        bus_if.track_para_ren_i = 1'b0;
        step(5);
        check_stream("restart", BL);

        // Commit and write while streaming: old table, no swap until ren low
        step(2);
        start_stream();
        step(10);
        commit_pulse();
        check("stream_pending", bus_if.cfg_pending_o, 1);
        bus_if.cfg_wr_en_i   = 1'b1;
        bus_if.cfg_wr_addr_i = 7'd0;
        bus_if.cfg_wr_data_i = 32'hFFFF_FFFF;
        step(1);
        bus_if.cfg_wr_en_i = 1'b0;
        check("stream_drop", bus_if.cfg_wr_drop_o, 1);
        step(190);
        check_stream("old_table", WN);
        check("stream_no_burst_end", be_cnt - be_base, 0);
        check("done_still_pending", bus_if.cfg_pending_o, 1);
        bus_if.track_para_ren_i = 1'b0;
        step(4);
        check("late_burst_end", be_cnt - be_base, 1);
        check("late_pending_clear", bus_if.cfg_pending_o, 0);

        // Make bank 1 active again, put the 5A table in bank 0, reset mid-burst
        commit_pulse();
        step(2);
        write_table(1);
        start_stream();
        n = 0;
        reached = 1'b0;
        for (int c = 0; c < 400; c++) begin
            step(1);
            if (bus_if.track_para_vld_o) n++;
            if (n == 3 * BL + 6) begin
                reached = 1'b1;
                break;
            end
        end
        check("mid_reached", reached, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_vld", bus_if.track_para_vld_o, 0);
        check("async_rst_data", bus_if.track_para_data_o, 0);
        check("async_rst_drop", bus_if.cfg_wr_drop_o, 0);
        check("async_rst_pending", bus_if.cfg_pending_o, 0);
        step(2);
        rst_n = 1'b1;
        base = log_data.size();
        step(10);
        check("rst_no_output", log_data.size() - base, 0);
        bus_if.track_para_ren_i = 1'b0;
        step(1);
        load_exp(1);
        start_stream();
        step(19);
        bus_if.track_para_ren_i = 1'b0;
        step(5);
        check_stream("post_rst_bank0", BL);

        // Scrambled table to tell the checksum beat from the stored word
        write_table(2);
        commit_pulse();
        step(2);
        load_exp(2);
        start_stream();
        step(200);
        check_stream("final_beat", WN);
        check("last_beat", (log_data.size() >= base + WN) ? log_data[base+WN-1] : 32'hx, exp_tbl[WN-1]);
        bus_if.track_para_ren_i = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
